// File: rtl/io_resp_pkg.sv
// Shared types and STAT field layout for the memory-mapped I/O responder.
package io_resp_pkg;

   typedef enum logic [2:0] {
      IO_TXD  = 3'd0,
      IO_RXD  = 3'd1,
      IO_STAT = 3'd2,
      IO_GPO  = 3'd3,
      IO_GPI  = 3'd4
   } io_addr_t;

   localparam int unsigned CNT_W         = 3;
   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_RX_FULL    = 2;
   localparam int unsigned ST_RX_EMPTY   = 3;
   localparam int unsigned ST_TX_DROP    = 4;
   localparam int unsigned ST_RX_UDF     = 5;
   localparam int unsigned ST_TX_CNT_LSB = 8;
   localparam int unsigned ST_RX_CNT_LSB = 12;

   typedef struct packed {
      logic             full;
      logic             empty;
      logic [CNT_W-1:0] count;
   } fifo_stat_t;

   function automatic logic [15:0] pack_stat(
      input fifo_stat_t tx,
      input fifo_stat_t rx,
      input logic       tx_drop,
      input logic       rx_udf
   );
      logic [15:0] s;
      s = '0;
      s[ST_TX_FULL]  = tx.full;
      s[ST_TX_EMPTY] = tx.empty;
      s[ST_RX_FULL]  = rx.full;
      s[ST_RX_EMPTY] = rx.empty;
      s[ST_TX_DROP]  = tx_drop;
      s[ST_RX_UDF]   = rx_udf;
      s[ST_TX_CNT_LSB +: CNT_W] = tx.count;
      s[ST_RX_CNT_LSB +: CNT_W] = rx.count;
      return s;
   endfunction

endpackage

// File: rtl/io_resp_fifo.sv
// Small circular FIFO with separate occupancy counter.
// Head output reads as zero while the FIFO is empty.
module io_fifo
   import io_resp_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [DW-1:0]    din,
   output logic [DW-1:0]    dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_N);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; dout is gated by empty instead.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_resp.sv
// CPU-side I/O responder: TX/RX stream FIFOs, STAT register and GPIO.
// Accesses are single-cycle; read data is combinational from current state.
module io_resp
   import io_resp_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iom_in,
   input  logic          wen_in,
   input  logic [2:0]    addr_in,
   input  logic [DW-1:0] wdata_in,
   output logic [DW-1:0] rdata_out,
   output logic [DW-1:0] tx_data_out,
   output logic          tx_valid_out,
   input  logic          tx_ready_in,
   input  logic [DW-1:0] rx_data_in,
   input  logic          rx_valid_in,
   output logic          rx_ready_out,
   output logic [DW-1:0] gpio_out,
   input  logic [DW-1:0] gpio_in
);

   logic             wr;
   logic             rd;
   logic             sel_txd;
   logic             sel_rxd;
   logic             sel_stat;
   logic             sel_gpo;
   logic             sel_gpi;

   logic             tx_push;
   logic             tx_pop;
   logic             tx_full;
   logic             tx_empty;
   logic [CNT_W-1:0] tx_count;

   logic             rx_push;
   logic             rx_pop;
   logic             rx_full;
   logic             rx_empty;
   logic [CNT_W-1:0] rx_count;
   logic [DW-1:0]    rx_head;

   logic             tx_drop;
   logic             rx_udf;
   logic             set_drop;
   logic             set_udf;
   logic             clr_drop;
   logic             clr_udf;

   logic [DW-1:0]    gpi_s1;
   logic [DW-1:0]    gpi_s2;
   logic [15:0]      stat;
   fifo_stat_t       tx_st;
   fifo_stat_t       rx_st;

   assign wr = iom_in && !wen_in;
   assign rd = iom_in && wen_in;

   always_comb begin
      sel_txd  = 1'b0;
      sel_rxd  = 1'b0;
      sel_stat = 1'b0;
      sel_gpo  = 1'b0;
      sel_gpi  = 1'b0;
      unique case (addr_in)
         IO_TXD:  sel_txd  = 1'b1;
         IO_RXD:  sel_rxd  = 1'b1;
         IO_STAT: sel_stat = 1'b1;
         IO_GPO:  sel_gpo  = 1'b1;
         IO_GPI:  sel_gpi  = 1'b1;
         default: ;
      endcase
   end

   // Full is sampled before any same-cycle pop, so a write to a full
   // FIFO is always dropped.
   assign tx_push  = wr && sel_txd;
   assign set_drop = tx_push && tx_full;
   assign tx_pop   = tx_valid_out && tx_ready_in;

   assign tx_valid_out = !tx_empty;

   io_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (wdata_in),
      .dout  (tx_data_out),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   assign rx_ready_out = !rx_full;
   assign rx_push      = rx_valid_in && rx_ready_out;
   assign rx_pop       = rd && sel_rxd;
   assign set_udf      = rx_pop && rx_empty;

   io_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_data_in),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   assign clr_drop = wr && sel_stat && wdata_in[ST_TX_DROP];
   assign clr_udf  = wr && sel_stat && wdata_in[ST_RX_UDF];

   // A set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_drop <= 1'b0;
         rx_udf  <= 1'b0;
      end else begin
         tx_drop <= set_drop | (tx_drop & ~clr_drop);
         rx_udf  <= set_udf | (rx_udf & ~clr_udf);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_out <= '0;
         gpi_s1   <= '0;
         gpi_s2   <= '0;
      end else begin
         if (wr && sel_gpo) gpio_out <= wdata_in;
         gpi_s1 <= gpio_in;
         gpi_s2 <= gpi_s1;
      end
   end

   always_comb begin
      tx_st = '{full: tx_full, empty: tx_empty, count: tx_count};
      rx_st = '{full: rx_full, empty: rx_empty, count: rx_count};
      stat  = pack_stat(tx_st, rx_st, tx_drop, rx_udf);
   end

   always_comb begin
      rdata_out = '0;
      if (rd) begin
         unique case (1'b1)
            sel_rxd:  rdata_out = rx_head;
            sel_stat: rdata_out = DW'(stat);
            sel_gpo:  rdata_out = gpio_out;
            sel_gpi:  rdata_out = gpi_s2;
            default:  rdata_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_resp.sv
// Directed plus randomized bench for io_resp against a queue-based model.
module tb_io_resp;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          iom;
   logic          wen;
   logic [2:0]    addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] gpio_o;
   logic [DW-1:0] gpio_i;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] q_tx[$];
   logic [15:0] q_rx[$];
   logic [15:0] g_hist[$];
   logic        m_drop;
   logic        m_udf;
   logic [15:0] m_gpo;

   always #5 clk = ~clk;

   io_resp #(.DW(DW), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .iom_in       (iom),
      .wen_in       (wen),
      .addr_in      (addr),
      .wdata_in     (wdata),
      .rdata_out    (rdata),
      .tx_data_out  (tx_data),
      .tx_valid_out (tx_valid),
      .tx_ready_in  (tx_ready),
      .rx_data_in   (rx_data),
      .rx_valid_in  (rx_valid),
      .rx_ready_out (rx_ready),
      .gpio_out     (gpio_o),
      .gpio_in      (gpio_i)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_stat();
      logic [15:0] s;
      s = '0;
      s[0] = (q_tx.size() == 4);
      s[1] = (q_tx.size() == 0);
      s[2] = (q_rx.size() == 4);
      s[3] = (q_rx.size() == 0);
      s[4] = m_drop;
      s[5] = m_udf;
      s[10:8]  = 3'(q_tx.size());
      s[14:12] = 3'(q_rx.size());
      return s;
   endfunction

   function automatic logic [15:0] m_rdata();
      if (!(iom && wen)) return '0;
      case (addr)
         3'd1:    return (q_rx.size() != 0) ? q_rx[0] : 16'h0;
         3'd2:    return m_stat();
         3'd3:    return m_gpo;
         3'd4:    return g_hist[1];
         default: return '0;
      endcase
   endfunction

   task automatic m_reset();
      q_tx.delete();
      q_rx.delete();
      g_hist = '{16'h0, 16'h0};
      m_drop = 1'b0;
      m_udf  = 1'b0;
      m_gpo  = '0;
   endtask

   task automatic m_edge();
      bit wr_a;
      bit rd_a;
      int ntx;
      int nrx;
      wr_a = iom && !wen;
      rd_a = iom && wen;
      ntx  = q_tx.size();
      nrx  = q_rx.size();
      if (ntx > 0 && tx_ready) void'(q_tx.pop_front());
      if (wr_a && addr == 3'd2) begin
         if (wdata[4]) m_drop = 1'b0;
         if (wdata[5]) m_udf  = 1'b0;
      end
      if (wr_a && addr == 3'd0) begin
         if (ntx == 4) m_drop = 1'b1;
         else q_tx.push_back(wdata);
      end
      if (rd_a && addr == 3'd1) begin
         if (nrx == 0) m_udf = 1'b1;
         else void'(q_rx.pop_front());
      end
      if (rx_valid && nrx < 4) q_rx.push_back(rx_data);
      if (wr_a && addr == 3'd3) m_gpo = wdata;
      g_hist.push_front(gpio_i);
      void'(g_hist.pop_back());
   endtask

   // Inputs are driven at posedge+1; outputs checked before the next edge.
   task automatic step();
      #1;
      chk("rdata", rdata, m_rdata());
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, q_tx.size() != 0});
      chk("tx_data", tx_data, (q_tx.size() != 0) ? q_tx[0] : 16'h0);
      chk("rx_ready", {15'b0, rx_ready}, {15'b0, q_rx.size() < 4});
      chk("gpio_out", gpio_o, m_gpo);
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iom = 1'b0;
      wen = 1'b1;
   endtask

   task automatic wr_io(input logic [2:0] a, input logic [15:0] d);
      iom   = 1'b1;
      wen   = 1'b0;
      addr  = a;
      wdata = d;
      step();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a,
                         input logic [15:0] exp);
      iom  = 1'b1;
      wen  = 1'b1;
      addr = a;
      #1;
      chk(tag, rdata, exp);
      step();
      idle();
   endtask

   task automatic rst_pulse();
      idle();
      rst = 1'b1;
      #1;
      chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0);
      chk("rst_tx_data", tx_data, 16'h0);
      chk("rst_rx_ready", {15'b0, rx_ready}, 16'h1);
      chk("rst_gpio", gpio_o, 16'h0);
      chk("rst_rdata", rdata, 16'h0);
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [15:0] txe [4];

   initial begin
      rst      = 1'b1;
      iom      = 1'b0;
      wen      = 1'b1;
      addr     = '0;
      wdata    = '0;
      tx_ready = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      gpio_i   = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rd_chk("stat_reset", 3'd2, 16'h000A);

      // TX ordering, overflow drop
      txe = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) wr_io(3'd0, txe[i]);
      wr_io(3'd0, 16'h5555);
      rd_chk("stat_tx_full", 3'd2, 16'h0419);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("tx_order", tx_data, txe[i]);
         step();
      end
      #1;
      chk("tx_drained", {15'b0, tx_valid}, 16'h0);
      wr_io(3'd2, 16'h0030);
      rd_chk("stat_drop_clr", 3'd2, 16'h000A);

      // RX path and underflow
      rx_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         rx_data = 16'hA000 + 16'(i);
         step();
      end
      rx_valid = 1'b0;
      rd_chk("stat_rx3", 3'd2, 16'h3002);
      rd_chk("rx_a001", 3'd1, 16'hA001);
      rd_chk("rx_a002", 3'd1, 16'hA002);
      rd_chk("rx_a003", 3'd1, 16'hA003);
      rd_chk("rx_udf_rd", 3'd1, 16'h0000);
      rd_chk("stat_udf", 3'd2, 16'h002A);
      wr_io(3'd2, 16'h0030);
      rd_chk("stat_udf_clr", 3'd2, 16'h000A);

      // RX full with simultaneous pop and push
      rx_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         rx_data = 16'hB000 + 16'(i);
         step();
      end
      rx_data = 16'hB005;
      #1;
      chk("rx_full_ready", {15'b0, rx_ready}, 16'h0);
      rd_chk("rx_b001", 3'd1, 16'hB001);
      #1;
      chk("rx_ready_pop", {15'b0, rx_ready}, 16'h1);
      step();
      rx_valid = 1'b0;
      #1;
      chk("rx_refull", {15'b0, rx_ready}, 16'h0);
      rd_chk("stat_rx4", 3'd2, 16'h4006);
      for (int i = 2; i <= 5; i++)
         rd_chk("rx_drain", 3'd1, 16'hB000 + 16'(i));

      // GPIO
      wr_io(3'd3, 16'hBEEF);
      #1;
      chk("gpo_out", gpio_o, 16'hBEEF);
      rd_chk("gpo_rd", 3'd3, 16'hBEEF);
      gpio_i = 16'h00F0;
      rd_chk("gpi_old0", 3'd4, 16'h0000);
      rd_chk("gpi_old1", 3'd4, 16'h0000);
      rd_chk("gpi_new", 3'd4, 16'h00F0);

      // Decode gating
      iom   = 1'b0;
      wen   = 1'b0;
      addr  = 3'd3;
      wdata = 16'h1234;
      step();
      idle();
      #1;
      chk("gpo_gated", gpio_o, 16'hBEEF);
      rd_chk("rd_a5", 3'd5, 16'h0);
      rd_chk("rd_a6", 3'd6, 16'h0);
      rd_chk("rd_a7", 3'd7, 16'h0);
      rd_chk("rd_txd", 3'd0, 16'h0);

      // Reset mid-stream
      tx_ready = 1'b0;
      wr_io(3'd0, 16'hAAAA);
      wr_io(3'd0, 16'hBBBB);
      rx_valid = 1'b1;
      rx_data  = 16'hCCCC;
      step();
      rx_valid = 1'b0;
      rst_pulse();
      rd_chk("stat_midrst", 3'd2, 16'h000A);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         iom      = 1'($urandom_range(0, 1));
         wen      = 1'($urandom_range(0, 1));
         addr     = 3'($urandom_range(0, 7));
         wdata    = 16'($urandom);
         tx_ready = ($urandom_range(0, 3) == 0);
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) gpio_i = 16'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/io_resp.md
Name: io_resp

Overview:
- Memory-mapped I/O responder for the mycpu core.
- It services the IOR/IOW accesses issued by the control unit's execute cycle, using `iom`, `wen` and the register-file address/data buses.
- It provides buffered TX/RX streams with valid/ready handshakes, a status register and GPIO.
- It is the device-side end of the CPU I/O interface and sits beside data memory in the top level.

Parameters:
- DW, 16, data width of CPU buses, FIFO entries and GPIO.
- DEPTH, 4, entries per TX and RX FIFO; power of two, 2..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- iom_in  in  1  I/O access select from control unit.
- wen_in  in  1  write enable, active-low; 0 together with iom_in=1 is an I/O write.
- addr_in  in  3  I/O port select, low bits of register A.
- wdata_in  in  DW  write data from register B.
- rdata_out  out  DW  read data, combinational, for the md=10 mux.
- tx_data_out  out  DW  TX stream data (TX FIFO head).
- tx_valid_out  out  1  TX FIFO not empty.
- tx_ready_in  in  1  external consumer ready.
- rx_data_in  in  DW  RX stream data.
- rx_valid_in  in  1  RX data valid.
- rx_ready_out  out  1  RX FIFO not full.
- gpio_out  out  DW  GPIO output register.
- gpio_in  in  DW  asynchronous GPIO inputs.

Behaviour:
- **Access decode.**
  - Write when iom_in=1 and wen_in=0.
  - Read when iom_in=1 and wen_in=1.
  - Each access is single-cycle, and all side effects take place at the next rising edge.
- **Port map.**
  - 0 TXD: write pushes to the TX FIFO; read returns 0.
  - 1 RXD: read returns the RX head and pops it; writes are ignored.
  - 2 STAT: read returns status; write clears the sticky bits selected by 1s in wdata_in[5:4].
  - 3 GPO: read/write of gpio_out.
  - 4 GPI: read returns synchronised gpio_in; writes are ignored.
  - 5..7: reads return 0; writes are ignored.
- **Read data.**
  - rdata_out is combinational from the current state and is valid in the same cycle as the access.
  - rdata_out = 0 whenever there is no read.
- **STAT bits.**
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] tx_drop (sticky), [5] rx_udf (sticky).
  - [10:8] tx_count, [14:12] rx_count.
  - All other bits are 0.
- **TX FIFO.**
  - Push on a TXD write when not full.
  - A write while full (evaluated at the start of the cycle) discards the data and sets tx_drop, even if an external pop happens in the same cycle.
  - Pop when tx_valid_out && tx_ready_in.
  - Simultaneous push and pop when not full: count unchanged, data order preserved.
- **RX FIFO.**
  - Push when rx_valid_in && rx_ready_out.
  - rx_ready_out = !rx_full, so no overflow is possible.
  - An RXD read while empty returns 0, does not pop, and sets rx_udf.
  - Simultaneous push and pop: count unchanged.
- **Pointers.** Pointer wrap-around is modulo DEPTH; the count is a separate 3-bit register.
- **Sticky bits.**
  - A clear via STAT write coinciding with a new set event: the set wins.
- **GPI.** Two-flop synchroniser; a change on gpio_in is visible on a GPI read 2 clocks later.
- **Reset (asynchronous, any time, including mid-transfer).**
  - FIFOs empty, counts 0, sticky bits 0.
  - gpio_out=0, synchroniser flops=0.
  - tx_valid_out=0, tx_data_out=0, rx_ready_out=1, rdata_out=0.
  - FIFO contents are lost.
- **Interaction with the control unit.** The control unit drives iom=0, wen=1 in its RST and INF states, so only EX0 generates accesses. The block still handles back-to-back accesses on consecutive cycles correctly.

Decomposition:
- **mycpu_pkg additions:**
  - io_addr_t enum: IO_TXD=3'd0, IO_RXD=3'd1, IO_STAT=3'd2, IO_GPO=3'd3, IO_GPI=3'd4.
  - Bit-index constants for STAT fields.
- **Sub-module io_fifo** (parameters DW, DEPTH):
  - Inputs push, pop, din.
  - Outputs dout (head), full, empty, count.
  - Ignores push when full and pop when empty.
  - Instantiated twice, for TX and RX.

Test Plan:
- **Reset:** assert rst mid-stream with 2 TX entries queued -> tx_valid_out=0, STAT reads 16'h000A, rx_ready_out=1, gpio_out=0.
- **TX order and full:**
  - Write TXD 16'h1111, 16'h2222, 16'h3333, 16'h4444, then 16'h5555 with tx_ready_in=0 -> STAT tx_count=4, tx_full=1, tx_drop=1.
  - Then raise tx_ready_in -> tx_data_out shows 1111, 2222, 3333, 4444 on consecutive cycles; 5555 never appears.
- **RX path:**
  - Drive 3 words 16'hA001..A003 with rx_valid_in -> rx_count=3.
  - RXD reads return A001, A002, A003 in order.
  - A 4th read returns 0 and sets rx_udf (STAT[5]=1).
  - Write STAT 16'h0030 -> STAT[5:4]=0.
- **Simultaneous push/pop:**
  - RX full (4 entries) with rx_valid_in held high: rx_ready_out=0.
  - An RXD read pops the head; next cycle rx_ready_out=1 and a push occurs; the count returns to 4.
- **GPIO:**
  - Write GPO 16'hBEEF -> gpio_out=BEEF next cycle and a GPO read returns BEEF.
  - Change gpio_in to 16'h00F0 -> GPI read returns old value for 2 cycles, then 00F0.
- **Decode gating:**
  - iom_in=0 with wen_in=0 and addr 3 -> gpio_out unchanged.
  - Reads of addresses 5..7 and TXD -> rdata_out=0.
